// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order writeback FIFO feeding the register-file write port, with forwarding lookups
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_rd,
    input  logic signed [XLEN-1:0]  in_data,
    input  logic                    wb_stall,
    output logic [4:0]              rd,
    output logic signed [XLEN-1:0]  write_data,
    output logic                    reg_write,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic signed [XLEN-1:0]  fwd1_data,
    output logic signed [XLEN-1:0]  fwd2_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            push;
    logic            store;
    logic            pop;
    logic [PW-1:0]   idx;

    assign in_ready   = (count < CW'(DEPTH));
    assign empty      = (count == '0);
    assign push       = in_valid && in_ready;
    // x0 results complete the handshake but never occupy an entry
    assign store      = push && (in_rd != 5'd0);
    assign reg_write  = !empty && !wb_stall;
    assign pop        = reg_write;
    assign rd         = empty ? 5'd0 : mem_rd[head];
    assign write_data = empty ? '0 : mem_data[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_rd[tail]   <= in_rd;
            mem_data[tail] <= in_data;
        end
    end

    // Walk oldest to youngest so the youngest occupied match wins
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (rs1 != 5'd0 && mem_rd[idx] == rs1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data[idx];
                end
                if (rs2 != 5'd0 && mem_rd[idx] == rs2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_data[idx];
                end
            end
        end
    end

endmodule
